dir_validator: RTL

- Downstream stage of the new-move controller.
- For one candidate square, one player and one signed step direction, the block walks the board memory cell by cell.
- It reports whether the line in that direction holds a contiguous run of opponent pieces closed by one of the mover's own pieces (an Othello capture line).
- It also reports the run length, which the later flip stage uses. The controller invokes it once per direction and ORs the results.

---
 rtl/othello_pkg.sv | 33 +++
 rtl/dir_validator.sv | 125 ++++++++++++
 2 files changed

// File: rtl/othello_pkg.sv
// Shared Othello board values: cell codes, board geometry, step directions
// and the direction-validator state encoding.
package othello_pkg;

  localparam int ADDR_W       = 7;
  localparam int BOARD_STRIDE = 10;
  localparam int BOARD_CELLS  = 100;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_BLACK  = 2'b01;
  localparam logic [1:0] CELL_WHITE  = 2'b10;
  localparam logic [1:0] CELL_BORDER = 2'b11;

  localparam logic signed [4:0] STEP_UP    = -5'sd10;
  localparam logic signed [4:0] STEP_DOWN  = 5'sd10;
  localparam logic signed [4:0] STEP_LEFT  = -5'sd1;
  localparam logic signed [4:0] STEP_RIGHT = 5'sd1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [1:0] own_cell(input logic player);
    return player ? CELL_WHITE : CELL_BLACK;
  endfunction

  function automatic logic [1:0] opp_cell(input logic player);
    return player ? CELL_BLACK : CELL_WHITE;
  endfunction

endpackage

// File: rtl/dir_validator.sv
// Walks the board from origin along one step direction and reports whether
// a run of opponent pieces is closed by the mover's own piece.
// Ports: clock/reset (sync, active-low); ld/enable + step/origin/player in;
// mem_addr_o/mem_rd_o/mem_data_i board RAM; s_done_o, dir_status_o,
// run_len_o, busy_o results.
module dir_validator #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld,
  input  logic              enable,
  input  logic [4:0]        step_in,
  input  logic [ADDR_W-1:0] origin_in,
  input  logic              player_in,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [1:0]        mem_data_i,
  output logic              s_done_o,
  output logic              dir_status_o,
  output logic [2:0]        run_len_o,
  output logic              busy_o
);
  import othello_pkg::*;

  logic [2:0]        state;
  logic [4:0]        step_q;
  logic [ADDR_W-1:0] origin_q;
  logic              player_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        count;
  logic [3:0]        wait_cnt;

  logic [7:0]        addr_ext;
  logic [7:0]        step_ext;
  logic [7:0]        next_s;
  logic [ADDR_W-1:0] next_addr;
  logic              in_range;
  logic              issue;
  logic [2:0]        count_inc;

  // 8-bit signed sum; bit 7 set means the step left the board below 0
  always_comb begin
    addr_ext  = 8'(cur_addr);
    step_ext  = {{3{step_q[4]}}, step_q};
    next_s    = addr_ext + step_ext;
    next_addr = next_s[ADDR_W-1:0];
    in_range  = !next_s[7] && (next_s <= 8'(BOARD_CELLS - 1));
    issue     = (state == S_ISSUE) && in_range;
    count_inc = count + 3'd1;
  end

  assign mem_addr_o = issue ? next_addr : addr_q;
  assign mem_rd_o   = issue;
  assign s_done_o   = (state == S_DONE);
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      step_q       <= '0;
      origin_q     <= '0;
      player_q     <= 1'b0;
      cur_addr     <= '0;
      addr_q       <= '0;
      count        <= '0;
      wait_cnt     <= '0;
      dir_status_o <= 1'b0;
      run_len_o    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ld) begin
            step_q   <= step_in;
            origin_q <= origin_in;
            player_q <= player_in;
          end
          if (enable) begin
            cur_addr     <= ld ? origin_in : origin_q;
            count        <= '0;
            dir_status_o <= 1'b0;
            run_len_o    <= '0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (in_range) begin
            cur_addr <= next_addr;
            addr_q   <= next_addr;
            wait_cnt <= '0;
            state    <= (RD_LATENCY == 1) ? S_EVAL : S_WAIT;
          end else begin
            state <= S_DONE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'(RD_LATENCY - 2)) begin
            state <= S_EVAL;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_EVAL: begin
          unique case (1'b1)
            (mem_data_i == opp_cell(player_q)): begin
              count <= count_inc;
              state <= (count_inc == 3'd7) ? S_DONE : S_ISSUE;
            end
            (mem_data_i == own_cell(player_q)): begin
              dir_status_o <= (count != 3'd0);
              run_len_o    <= count;
              state        <= S_DONE;
            end
            default: state <= S_DONE;
          endcase
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
